// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package mdu_pkg;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Two's-complement negate when en is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic is_signed);
    return neg_if(x, is_signed & x[WIDTH-1]);
  endfunction
endpackage

// File: rtl/mdu_addsub.sv
// (WIDTH+1)-bit adder/subtractor with carry-out, shared by multiply and divide.
module mdu_addsub
  import mdu_pkg::*;
(
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           co
);
  localparam int unsigned EXT_W = WIDTH + 2;

  logic [WIDTH:0] b_eff;

  always_comb begin
    b_eff     = sub ? ~b : b;
    {co, sum} = {1'b0, a} + {1'b0, b_eff} + EXT_W'(sub);
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete as no-ops.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Op_A,
  input  logic [WIDTH-1:0] Op_B,
  input  logic             hi_write,
  input  logic             lo_write,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_lo;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   low;
  logic [WIDTH-1:0]   opnd;

  logic               sgn_c;
  logic [WIDTH-1:0]   lat_opnd_c;
  logic [WIDTH-1:0]   lat_low_c;
  logic               lat_neg_lo_c;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH:0]     add_sum;
  logic               add_sub;
  logic               add_co;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
`ifdef MDU_DIV_EN
  logic               neg_hi;
  logic               lat_neg_hi_c;
  logic               div_by_zero_c;
`else
  logic               done_dly;
  logic               unused_co;
`endif

  assign busy     = (state != IDLE);
  assign prod     = {rem[WIDTH-1:0], low};
  assign prod_neg = ~prod + (2*WIDTH)'(1);

  // Operand preparation at issue; a zero divisor keeps the raw dividend so HI returns it.
  always_comb begin
    sgn_c        = ~op[0];
    lat_opnd_c   = abs_val(Op_A, sgn_c);
    lat_low_c    = abs_val(Op_B, sgn_c);
    lat_neg_lo_c = sgn_c & (Op_A[WIDTH-1] ^ Op_B[WIDTH-1]);
`ifdef MDU_DIV_EN
    div_by_zero_c = (Op_B == '0);
    lat_neg_hi_c  = sgn_c & ~div_by_zero_c & Op_A[WIDTH-1];
    if (op[1]) begin
      lat_opnd_c   = abs_val(Op_B, sgn_c);
      lat_low_c    = abs_val(Op_A, sgn_c & ~div_by_zero_c);
      lat_neg_lo_c = lat_neg_lo_c & ~div_by_zero_c;
    end
`endif
  end

  // Multiply adds the multiplicand when the multiplier LSB is set; divide trial-subtracts.
  always_comb begin
    add_a   = rem;
    add_b   = {1'b0, {WIDTH{low[0]}} & opnd};
    add_sub = 1'b0;
`ifdef MDU_DIV_EN
    if (is_div) begin
      add_a   = {rem[WIDTH-1:0], low[WIDTH-1]};
      add_b   = {1'b0, opnd};
      add_sub = 1'b1;
    end
`endif
  end

  mdu_addsub u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum),
    .co  (add_co)
  );

`ifndef MDU_DIV_EN
  assign unused_co = add_co;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      rem    <= '0;
      low    <= '0;
      opnd   <= '0;
      HI     <= '0;
      LO     <= '0;
      done   <= 1'b0;
`ifdef MDU_DIV_EN
      neg_hi <= 1'b0;
`else
      done_dly <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifndef MDU_DIV_EN
      done_dly <= 1'b0;
      if (done_dly) done <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_lo <= lat_neg_lo_c;
            opnd   <= lat_opnd_c;
            low    <= lat_low_c;
            rem    <= '0;
            cnt    <= '0;
`ifdef MDU_DIV_EN
            neg_hi <= lat_neg_hi_c;
            state  <= CALC;
`else
            state  <= op[1] ? FIX : CALC;
`endif
          end else begin
            if (hi_write) HI <= Op_A;
            if (lo_write) LO <= Op_A;
          end
        end
        CALC: begin
`ifdef MDU_DIV_EN
          if (is_div) begin
            rem <= add_co ? add_sum : add_a;
            low <= {low[WIDTH-2:0], add_co};
          end else begin
            rem <= {1'b0, add_sum[WIDTH:1]};
            low <= {add_sum[0], low[WIDTH-1:1]};
          end
`else
          rem <= {1'b0, add_sum[WIDTH:1]};
          low <= {add_sum[0], low[WIDTH-1:1]};
`endif
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER_COUNT - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          if (is_div) begin
`ifdef MDU_DIV_EN
            LO   <= neg_if(low, neg_lo);
            HI   <= neg_if(rem[WIDTH-1:0], neg_hi);
            done <= 1'b1;
`else
            done_dly <= 1'b1;
`endif
          end else begin
            {HI, LO} <= neg_lo ? prod_neg : prod;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: vector table plus multi-cycle corner sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Op_A;
  logic [31:0] Op_B;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec;
  int n_err;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  mult_div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .Op_A     (Op_A),
    .Op_B     (Op_B),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .busy     (busy),
    .done     (done),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive start for one edge (E0); returns #1 after E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    Op_A  = a;
    Op_B  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after E0; counts edges until done and post-edge samples with busy high.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int          lat;
    int          busy_n;
    int          exp_lat;
    int          exp_busy;
    int          cnt_done;
    int          cnt_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MDU_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{MDU_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4]  = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[5]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[7]  = '{MDU_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
    vecs[8]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[9]  = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    Op_A     = '0;
    Op_B     = '0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    mdl_hi   = '0;
    mdl_lo   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", 64'(HI), 64'h0);
    check("reset_lo", 64'(LO), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      exp_hi   = vecs[i].hi;
      exp_lo   = vecs[i].lo;
      exp_lat  = 33;
      exp_busy = 33;
`ifndef MDU_DIV_EN
      if (vecs[i].op[1]) begin
        exp_hi   = mdl_hi;
        exp_lo   = mdl_lo;
        exp_lat  = 2;
        exp_busy = 1;
      end
`endif
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, busy_n);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), 64'(exp_busy));
      check($sformatf("v%0d_hi", i), 64'(HI), 64'(exp_hi));
      check($sformatf("v%0d_lo", i), 64'(LO), 64'(exp_lo));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_one_cycle", i), 64'(done), 64'h0);
      mdl_hi = exp_hi;
      mdl_lo = exp_lo;
    end

    // start and MTHI/MTLO while busy are ignored
    issue(MDU_MULTU, 32'd3, 32'd5);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin
        start    = 1'b1;
        op       = MDU_MULT;
        Op_A     = 32'h12345678;
        Op_B     = 32'd7;
        hi_write = 1'b1;
        lo_write = 1'b1;
      end else begin
        start    = 1'b0;
        hi_write = 1'b0;
        lo_write = 1'b0;
      end
    end
    start    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    check("busy_ign_latency", 64'(lat), 64'd33);
    check("busy_ign_hi", 64'(HI), 64'h0);
    check("busy_ign_lo", 64'(LO), 64'd15);
    cnt_busy = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (busy) cnt_busy++;
    end
    check("busy_ign_not_queued", 64'(cnt_busy), 64'h0);

    // MTHI in IDLE
    @(negedge clk);
    hi_write = 1'b1;
    Op_A     = 32'h12345678;
    @(posedge clk);
    #1;
    hi_write = 1'b0;
    check("mthi_hi", 64'(HI), 64'h12345678);
    check("mthi_lo_kept", 64'(LO), 64'd15);

    // MTHI and MTLO together
    @(negedge clk);
    hi_write = 1'b1;
    lo_write = 1'b1;
    Op_A     = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    hi_write = 1'b0;
    lo_write = 1'b0;
    check("mthilo_hi", 64'(HI), 64'hCAFEF00D);
    check("mthilo_lo", 64'(LO), 64'hCAFEF00D);

    // start beats a simultaneous MTHI/MTLO
    @(negedge clk);
    start    = 1'b1;
    op       = MDU_MULTU;
    Op_A     = 32'd2;
    Op_B     = 32'd3;
    hi_write = 1'b1;
    lo_write = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    check("start_wins_hi", 64'(HI), 64'hCAFEF00D);
    check("start_wins_busy", 64'(busy), 64'h1);
    wait_done(lat, busy_n);
    check("start_wins_latency", 64'(lat), 64'd33);
    check("start_wins_res_hi", 64'(HI), 64'h0);
    check("start_wins_res_lo", 64'(LO), 64'd6);

    // Reset in the middle of an operation
    @(negedge clk);
    hi_write = 1'b1;
    lo_write = 1'b1;
    Op_A     = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    hi_write = 1'b0;
    lo_write = 1'b0;
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_hi", 64'(HI), 64'h0);
    check("abort_lo", 64'(LO), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    cnt_done = 0;
    cnt_busy = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("abort_no_done", 64'(cnt_done), 64'h0);
    check("abort_stays_idle", 64'(cnt_busy), 64'h0);

    // Back-to-back issue in the done cycle
    issue(MDU_MULTU, 32'd6, 32'd7);
    wait_done(lat, busy_n);
    check("b2b_first_latency", 64'(lat), 64'd33);
    check("b2b_first_hi", 64'(HI), 64'h0);
    check("b2b_first_lo", 64'(LO), 64'd42);
    start = 1'b1;
    op    = MDU_MULT;
    Op_A  = 32'hFFFFFFFE;
    Op_B  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second_busy", 64'(busy), 64'h1);
    wait_done(lat, busy_n);
    check("b2b_second_latency", 64'(lat), 64'd33);
    check("b2b_second_hi", 64'(HI), 64'hFFFFFFFF);
    check("b2b_second_lo", 64'(LO), 64'hFFFFFFFA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative HI/LO multiply/divide unit for the 32-bit MIPS core. It sits directly downstream of the register bank: rs and rt read data feed Op_A/Op_B. It executes MULT, MULTU, DIV and DIVU over 33 cycles and holds the architectural HI/LO registers. It also services MTHI/MTLO writes, and its HI/LO outputs feed the MFHI/MFLO write-back mux.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request an operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- Op_A  input  WIDTH  rs data: multiplicand/dividend, also MTHI/MTLO source
- Op_B  input  WIDTH  rt data: multiplier/divisor
- hi_write  input  1  MTHI: HI <= Op_A
- lo_write  input  1  MTLO: LO <= Op_A
- busy  output  1  operation in progress; pipeline stalls MFHI/MFLO on it
- done  output  1  one-cycle pulse, coincident with first cycle new HI/LO is visible
- HI  output  WIDTH  product high word / remainder
- LO  output  WIDTH  product low word / quotient

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start=1:
  - latch op, sign flags, |Op_A| and |Op_B| (absolute value only for signed ops);
  - counter <= 0; go to CALC.
- CALC: one iteration per cycle, 32 iterations (counter 0..31), then go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 33-bit partial remainder.
- FIX: apply sign correction, then write HI/LO.
  - Signed product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Then done <= 1, state <= IDLE.
- Divide by zero, signed or unsigned: same 33-cycle path; result LO=32'hFFFFFFFF, HI=Op_A (original, unsigned-extended value).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap, no trap).
- start while busy: ignored, not queued.
- hi_write/lo_write:
  - In IDLE, the write takes effect at the next edge; both may be set in the same cycle.
  - While busy, they are ignored.
- start together with hi_write/lo_write in IDLE: start wins, writes dropped.
- HI/LO hold their value between operations; they are never cleared except by reset.

## Timing
- Reset (async assert, sync deassert by the surrounding reset tree):
  - state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0.
  - Reset asserted mid-operation aborts it; no done is produced.
- Edge E0 samples start. busy=1 from after E0 through the cycle before E33.
- E1..E32: CALC iterations.
- E33 (FIX → IDLE):
  - HI/LO updated, done=1 for exactly one cycle, busy=0.
  - A new start may be sampled at E34 (done cycle); back-to-back issue is allowed.
- Latency: 33 cycles from start edge to result-visible edge, independent of operand values.
- MTHI/MTLO latency: 1 cycle.
- done is registered; busy is decoded from state (registered).

## Configuration
- MDU_DIV_EN defined: DIV/DIVU implemented as above.
- MDU_DIV_EN undefined:
  - Divider datapath is not compiled.
  - A DIV/DIVU start is accepted, busy=1 for one cycle, and done pulses at E2.
  - HI/LO are unchanged.
  - Multiply behaviour is identical in both builds.

## Structure
- Package mdu_pkg holds:
  - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU);
  - the state enum (IDLE, CALC, FIX);
  - WIDTH default and ITER_COUNT=32.
- Sub-module mdu_addsub: a (WIDTH+1)-bit adder/subtractor with carry-out, shared by the multiply accumulate and the divide trial subtraction.
- Everything else (control FSM, counter, HI/LO, sign fix) stays in mult_div_unit.

## Test plan
- MULTU Op_A=0xFFFFFFFF, Op_B=0xFFFFFFFF → at E33 HI=0xFFFFFFFE, LO=0x00000001, done pulses once, busy low after.
- MULT Op_A=0xFFFFFFFD (-3), Op_B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV Op_A=0xFFFFFFF9 (-7), Op_B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 → LO=0x0000000E, HI=0x00000002.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=0x00000005; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- During busy, pulse start with new operands and pulse hi_write with Op_A=0x12345678 → both ignored; original result appears at E33. In IDLE, hi_write with 0x12345678 → HI=0x12345678 next cycle, LO unchanged.
- Assert rst_n=0 at cycle 10 of a MULTU → HI=LO=0, busy=0 immediately, no done. Back-to-back start at the done cycle → second result at 33 cycles later.
